sipo_latch_ctrl: RTL

//  Upstream driver for a bank of level-sensitive D latches (enable + data per bit).
//  - Accepts a serial bit stream over a valid/ready handshake, one bit per accepted cycle.
//  - Assembles WIDTH bits, MSB first, then presents the word on o_latch_d.
//  - Drives o_latch_en high only while o_latch_d is stable: SETUP cycles before, HOLD cycles after.
//  - Purpose: a transparent latch never sees data change while its enable is high.

---
 rtl/sipo_latch_ctrl_pkg.sv | 21 ++
 rtl/sipo_latch_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/sipo_latch_ctrl_pkg.sv
// Shared definitions for the serial-in, parallel-out latch-bank driver:
// FSM state encoding and counter sizing helper.
package sipo_latch_ctrl_pkg;

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sipo_latch_ctrl.sv
// Collects a serial bit stream into a word and drives a transparent latch bank
// so that the data is stable for the whole setup / enable / hold window.
module sipo_latch_ctrl
  import sipo_latch_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  output logic             o_bit_ready,
  output logic             o_latch_en,
  output logic [WIDTH-1:0] o_latch_d,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = $clog2(max4(WIDTH, SETUP_CYC, EN_CYC, HOLD_CYC) + 1);

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   next_word;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   phase_cnt;

  assign next_word   = {shreg[WIDTH-2:0], i_bit};
  assign o_bit_ready = (state == SHIFT);
  assign o_busy      = (state != SHIFT);

  // o_latch_d is only loaded on the last accepted bit, so it cannot move
  // while the enable window is open; the enable itself is set/cleared on the
  // state transitions around ENABLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= SHIFT;
      shreg      <= '0;
      bit_cnt    <= '0;
      phase_cnt  <= '0;
      o_latch_en <= 1'b0;
      o_latch_d  <= '0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        SHIFT: begin
          if (i_bit_valid) begin
            shreg <= next_word;
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              o_latch_d <= next_word;
              bit_cnt   <= '0;
              phase_cnt <= '0;
              state     <= SETUP;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        SETUP: begin
          if (phase_cnt == CNT_W'(SETUP_CYC - 1)) begin
            phase_cnt  <= '0;
            o_latch_en <= 1'b1;
            state      <= ENABLE;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        ENABLE: begin
          if (phase_cnt == CNT_W'(EN_CYC - 1)) begin
            phase_cnt  <= '0;
            o_latch_en <= 1'b0;
            state      <= HOLD;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (phase_cnt == CNT_W'(HOLD_CYC - 1)) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            o_done    <= 1'b1;
            state     <= SHIFT;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        default: begin
          state      <= SHIFT;
          o_latch_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
